wb_button_led: RTL and testbench

Wishbone B4 classic responder in the Caravan user project area that owns the board-level push-button inputs (mprj_io[2:0]) and LED outputs (mprj_io[10:3]). It synchronises and debounces three buttons, records press events in sticky status bits, and drives eight LEDs either from a firmware-written register or by mirroring the debounced buttons. It is the device side of the button/LED path that the chip-level testbench stimulates and observes. Its reset state mirrors the buttons to the LEDs with no firmware involvement.

---
 rtl/wb_button_led_pkg.sv | 28 ++
 rtl/wb_button_led_if.sv | 21 ++
 rtl/wb_button_led_btn_debounce.sv | 43 ++++
 rtl/wb_button_led.sv | 114 +++++++++++
 tb/tb_wb_button_led.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_button_led_pkg.sv
// Shared constants for the button/LED Wishbone block: register word offsets,
// field positions, and the button-to-LED mirror mapping.
package wb_button_led_pkg;

    localparam int NUM_BTN = 3;
    localparam int NUM_LED = 8;

    // Word offsets (adr[7:2])
    localparam logic [5:0] REG_CTRL     = 6'h00;
    localparam logic [5:0] REG_LED      = 6'h01;
    localparam logic [5:0] REG_STATUS   = 6'h02;
    localparam logic [5:0] REG_DEBOUNCE = 6'h03;
    localparam logic [5:0] REG_IRQ_EN   = 6'h04;

    localparam int CTRL_MODE_BIT  = 0;
    localparam int STATUS_EVT_LSB = 8;

    // LED k follows button (k mod NUM_BTN) so all buttons pressed lights every LED.
    function automatic logic [NUM_LED-1:0] mirror_leds(input logic [NUM_BTN-1:0] lvl);
        logic [NUM_LED-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_LED; k++) begin
            r[k] = lvl[k % NUM_BTN];
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_button_led_if.sv
// Wishbone B4 classic bus bundle for the button/LED responder.
interface wb_button_led_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_button_led_btn_debounce.sv
// One button path: 2-flop synchroniser, stable-cycle counter, debounced level.
// rise pulses in the cycle before level goes 0->1 so events land on the same edge.
module btn_debounce (
    input  logic        wb_clk_i,
    input  logic        wb_rstn_i,
    input  logic        pin,
    input  logic [15:0] n,
    output logic        level,
    output logic        rise
);

    logic        sync_a;
    logic        sync_b;
    logic [15:0] cnt;
    logic [15:0] limit;
    logic        fire;

    // N=0 is treated as N=1
    assign limit = (n == 16'd0) ? 16'd0 : n - 16'd1;
    assign fire  = (sync_b != level) && (cnt == limit);
    assign rise  = fire && sync_b;

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
        end else begin
            sync_a <= pin;
            sync_b <= sync_a;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (fire) begin
                level <= sync_b;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/wb_button_led.sv
// Wishbone responder owning three debounced buttons and eight LEDs.
// Define BUTTON_IRQ_EN to include the IRQ_EN register and irq_o logic.
module wb_button_led
    import wb_button_led_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [15:0] DB_RESET  = 16'd8
) (
    input  logic                wb_clk_i,
    input  logic                wb_rstn_i,
    wb_button_led_if.slave      wb,
    input  logic [NUM_BTN-1:0]  btn_i,
    output logic [NUM_LED-1:0]  led_o,
    output logic                irq_o
);

    logic               hit;
    logic               access;
    logic               wr_en;
    logic [5:0]         word;
    logic [31:0]        rdata;
    logic               mode;
    logic [NUM_LED-1:0] led_reg;
    logic [15:0]        db_n;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] events;
    logic [NUM_BTN-1:0] evt_clr;
    logic               unused_bits;

    assign unused_bits = ^{wb.wbs_adr_i[1:0], wb.wbs_dat_i[31:16], wb.wbs_sel_i[3:2]};

    assign hit    = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign access = hit & ~wb.wbs_ack_o;
    assign wr_en  = access & wb.wbs_we_i;
    assign word   = wb.wbs_adr_i[7:2];

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce u_db (
            .wb_clk_i  (wb_clk_i),
            .wb_rstn_i (wb_rstn_i),
            .pin       (btn_i[i]),
            .n         (db_n),
            .level     (level[i]),
            .rise      (rise[i])
        );
    end

`ifdef BUTTON_IRQ_EN
    logic [NUM_BTN-1:0] irq_en;

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            irq_en <= '0;
        end else if (wr_en && word == REG_IRQ_EN && wb.wbs_sel_i[0]) begin
            irq_en <= wb.wbs_dat_i[NUM_BTN-1:0];
        end
    end

    assign irq_o = |(events & irq_en);
`else
    assign irq_o = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (word)
            REG_CTRL:     rdata[CTRL_MODE_BIT] = mode;
            REG_LED:      rdata[NUM_LED-1:0] = led_reg;
            REG_STATUS: begin
                rdata[NUM_BTN-1:0] = level;
                rdata[STATUS_EVT_LSB +: NUM_BTN] = events;
            end
            REG_DEBOUNCE: rdata[15:0] = db_n;
`ifdef BUTTON_IRQ_EN
            REG_IRQ_EN:   rdata[NUM_BTN-1:0] = irq_en;
`endif
            default:      rdata = '0;
        endcase
    end

    // A rising event in the same cycle as its W1C clear survives the clear
    assign evt_clr = (wr_en && word == REG_STATUS && wb.wbs_sel_i[1])
                   ? wb.wbs_dat_i[STATUS_EVT_LSB +: NUM_BTN] : '0;

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            wb.wbs_ack_o <= 1'b0;
            wb.wbs_dat_o <= '0;
            mode         <= 1'b1;
            led_reg      <= '0;
            db_n         <= DB_RESET;
            events       <= '0;
        end else begin
            wb.wbs_ack_o <= access;
            wb.wbs_dat_o <= access ? rdata : 32'h0;
            events       <= (events & ~evt_clr) | rise;
            if (wr_en) begin
                case (word)
                    REG_CTRL: if (wb.wbs_sel_i[0]) mode <= wb.wbs_dat_i[CTRL_MODE_BIT];
                    REG_LED:  if (wb.wbs_sel_i[0]) led_reg <= wb.wbs_dat_i[NUM_LED-1:0];
                    REG_DEBOUNCE: begin
                        if (wb.wbs_sel_i[0]) db_n[7:0]  <= wb.wbs_dat_i[7:0];
                        if (wb.wbs_sel_i[1]) db_n[15:8] <= wb.wbs_dat_i[15:8];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign led_o = mode ? mirror_leds(level) : led_reg;

endmodule

// File: tb/tb_wb_button_led.sv
// Directed plus randomized bench for wb_button_led, checked every cycle against
// a behavioural model (sliding-window debounce over sampled pin history).
module tb_wb_button_led;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_LED  = BASE + 32'h04;
    localparam logic [31:0] A_STAT = BASE + 32'h08;
    localparam logic [31:0] A_DB   = BASE + 32'h0C;
    localparam logic [31:0] A_IEN  = BASE + 32'h10;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic [2:0] btn  = 3'b000;
    logic [7:0] led;
    logic       irq;

    int total = 0;
    int bad   = 0;

    wb_button_led_if bus ();

    wb_button_led dut (
        .wb_clk_i  (clk),
        .wb_rstn_i (rstn),
        .wb        (bus),
        .btn_i     (btn),
        .led_o     (led),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic        m_mode;
    logic [7:0]  m_led;
    logic [2:0]  m_ev;
    logic [15:0] m_n;
    logic [2:0]  m_ien;
    logic [2:0]  m_db;
    logic        m_ack;
    logic [31:0] m_dat;
    logic [2:0]  hq[$];

    function automatic logic [2:0] past(int back);
        int idx = hq.size() - 1 - back;
        return (idx >= 0) ? hq[idx] : 3'b000;
    endfunction

    // A button flips once its pin, seen two clocks late, has held the other level for N samples
    function automatic logic [2:0] flip_vec();
        logic [2:0] f;
        logic [2:0] s;
        int n = (m_n == 16'd0) ? 1 : int'(m_n);
        f = 3'b000;
        for (int i = 0; i < 3; i++) begin
            f[i] = 1'b1;
            for (int j = 2; j <= n + 1; j++) begin
                s = past(j);
                if (s[i] == m_db[i]) f[i] = 1'b0;
            end
        end
        return f;
    endfunction

    function automatic logic m_hit();
        return bus.wbs_cyc_i && bus.wbs_stb_i && (bus.wbs_adr_i[31:8] == BASE[31:8]);
    endfunction

    function automatic logic [31:0] m_read(logic [5:0] w);
        case (w)
            6'd0: return {31'b0, m_mode};
            6'd1: return {24'b0, m_led};
            6'd2: return {21'b0, m_ev, 5'b0, m_db};
            6'd3: return {16'b0, m_n};
`ifdef BUTTON_IRQ_EN
            6'd4: return {29'b0, m_ien};
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [2:0] m_clr();
        if (m_hit() && !m_ack && bus.wbs_we_i && bus.wbs_adr_i[7:2] == 6'd2 && bus.wbs_sel_i[1])
            return bus.wbs_dat_i[10:8];
        return 3'b000;
    endfunction

    function automatic logic [7:0] m_led_out();
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = m_db[k % 3];
        return m_mode ? r : m_led;
    endfunction

    function automatic logic m_irq();
`ifdef BUTTON_IRQ_EN
        return |(m_ev & m_ien);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_mode <= 1'b1;
            m_led  <= 8'h00;
            m_ev   <= 3'b000;
            m_n    <= 16'd8;
            m_ien  <= 3'b000;
            m_db   <= 3'b000;
            m_ack  <= 1'b0;
            m_dat  <= 32'h0;
            hq.delete();
        end else begin
            hq.push_back(btn);
            if (hq.size() > 64) void'(hq.pop_front());
            m_db  <= m_db ^ flip_vec();
            m_ev  <= (m_ev & ~m_clr()) | (flip_vec() & ~m_db);
            m_ack <= m_hit() && !m_ack;
            m_dat <= (m_hit() && !m_ack) ? m_read(bus.wbs_adr_i[7:2]) : 32'h0;
            if (m_hit() && !m_ack && bus.wbs_we_i) begin
                case (bus.wbs_adr_i[7:2])
                    6'd0: if (bus.wbs_sel_i[0]) m_mode <= bus.wbs_dat_i[0];
                    6'd1: if (bus.wbs_sel_i[0]) m_led <= bus.wbs_dat_i[7:0];
                    6'd3: begin
                        if (bus.wbs_sel_i[0]) m_n[7:0]  <= bus.wbs_dat_i[7:0];
                        if (bus.wbs_sel_i[1]) m_n[15:8] <= bus.wbs_dat_i[15:8];
                    end
`ifdef BUTTON_IRQ_EN
                    6'd4: if (bus.wbs_sel_i[0]) m_ien <= bus.wbs_dat_i[2:0];
`endif
                    default: ;
                endcase
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("ack", {31'b0, bus.wbs_ack_o}, {31'b0, m_ack});
        chk("led", {24'b0, led}, {24'b0, m_led_out()});
        chk("irq", {31'b0, irq}, {31'b0, m_irq()});
        if (m_ack) chk("rdata", bus.wbs_dat_o, m_dat);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                        input logic [3:0] sel, output logic [31:0] rdat, output logic acked);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = wdat;
        bus.wbs_sel_i = sel;
        acked = 1'b0;
        rdat  = 32'h0;
        for (int i = 0; i < 4 && !acked; i++) begin
            tick();
            if (bus.wbs_ack_o === 1'b1) begin
                acked = 1'b1;
                rdat  = bus.wbs_dat_o;
            end
        end
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] r;
        logic a;
        xfer(adr, 1'b1, d, sel, r, a);
        chk("wr_ack", {31'b0, a}, 32'd1);
    endtask

    task automatic rd(input logic [31:0] adr, output logic [31:0] d);
        logic a;
        xfer(adr, 1'b0, 32'h0, 4'hF, d, a);
        chk("rd_ack", {31'b0, a}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        logic        a;
        logic        seen;

        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = 32'h0;
        bus.wbs_dat_i = 32'h0;

        #12;
        chk("rst_ack", {31'b0, bus.wbs_ack_o}, 32'd0);
        chk("rst_dat", bus.wbs_dat_o, 32'd0);
        chk("rst_led", {24'b0, led}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        ticks(3);

        // mirror: all buttons -> all LEDs within N+4
        btn  = 3'b111;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            if (led === 8'hFF) seen = 1'b1;
        end
        chk("mirror_ff", {24'b0, led}, 32'hFF);
        rd(A_STAT, d);
        chk("status_707", d, 32'h0000_0707);

        // register mode and byte lanes
        wr(A_CTRL, 32'h0, 4'h1);
        wr(A_LED, 32'h0000_00A5, 4'b0001);
        tick();
        chk("led_a5", {24'b0, led}, 32'hA5);
        wr(A_LED, 32'h0000_FF00, 4'b0010);
        tick();
        chk("led_lane", {24'b0, led}, 32'hA5);

        // bounce rejection, event set, W1C
        wr(A_STAT, 32'h700, 4'hF);
        btn = 3'b000;
        ticks(12);
        rd(A_STAT, d);
        chk("status_clear", d, 32'h0);
        btn = 3'b010;
        ticks(3);
        btn = 3'b000;
        ticks(15);
        rd(A_STAT, d);
        chk("bounce", d, 32'h0);
        btn = 3'b010;
        ticks(20);
        rd(A_STAT, d);
        chk("event9", d, 32'h202);
        wr(A_STAT, 32'h200, 4'hF);
        rd(A_STAT, d);
        chk("w1c9", d, 32'h002);

        // rising edge coincident with W1C of the same bit: set wins
        btn = 3'b000;
        ticks(12);
        btn = 3'b001;
        ticks(9);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b1;
        bus.wbs_adr_i = A_STAT;
        bus.wbs_dat_i = 32'h100;
        bus.wbs_sel_i = 4'hF;
        tick();
        chk("race_ack", {31'b0, bus.wbs_ack_o}, 32'd1);
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        tick();
        rd(A_STAT, d);
        chk("race_set_wins", d, 32'h101);
        wr(A_STAT, 32'h100, 4'hF);

        // interrupt
        wr(A_IEN, 32'h4, 4'h1);
        rd(A_IEN, d);
`ifdef BUTTON_IRQ_EN
        chk("ien_rd", d, 32'h4);
`else
        chk("ien_rd", d, 32'h0);
`endif
        btn = 3'b101;
        ticks(12);
`ifdef BUTTON_IRQ_EN
        chk("irq_set", {31'b0, irq}, 32'd1);
`else
        chk("irq_set", {31'b0, irq}, 32'd0);
`endif
        rd(A_STAT, d);
        chk("status_405", d, 32'h405);
        wr(A_STAT, 32'h400, 4'hF);
        chk("irq_clr", {31'b0, irq}, 32'd0);

        // window decode
        rd(BASE + 32'h20, d);
        chk("unmapped_rd", d, 32'h0);
        wr(BASE + 32'h20, 32'hFFFF_FFFF, 4'hF);
        xfer(BASE + 32'h100, 1'b0, 32'h0, 4'hF, d, a);
        chk("oob_noack", {31'b0, a}, 32'd0);
        rd(A_DB, d);
        chk("db_reset", d, 32'd8);

        // randomized phase at N=3
        wr(A_DB, 32'h3, 4'b0011);
        for (int it = 0; it < 60; it++) begin
            btn = 3'($urandom_range(0, 7));
            ticks($urandom_range(1, 8));
            case ($urandom_range(0, 5))
                0: rd(A_STAT, d);
                1: wr(A_CTRL, $urandom, 4'($urandom));
                2: wr(A_LED, $urandom, 4'($urandom));
                3: wr(A_STAT, $urandom, 4'($urandom));
                default: ;
            endcase
        end

        // N=0 behaves as N=1: third edge after the change updates the level
        wr(A_CTRL, 32'h1, 4'h1);
        btn = 3'b000;
        ticks(10);
        wr(A_DB, 32'h0, 4'b0011);
        ticks(2);
        btn = 3'b111;
        ticks(2);
        chk("n0_early", {24'b0, led}, 32'h00);
        tick();
        chk("n0_ff", {24'b0, led}, 32'hFF);

        // reset in the middle of an acked access
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = A_LED;
        bus.wbs_sel_i = 4'hF;
        tick();
        chk("pre_rst_ack", {31'b0, bus.wbs_ack_o}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("rst_drop_ack", {31'b0, bus.wbs_ack_o}, 32'd0);
        chk("rst_drop_led", {24'b0, led}, 32'd0);
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        rd(A_CTRL, d);
        chk("ctrl_after_rst", d, 32'h1);
        rd(A_DB, d);
        chk("db_after_rst", d, 32'd8);
        ticks(12);
        chk("mirror_after_rst", {24'b0, led}, 32'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
